// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with blocking, word-at-a-time line refill.
// Hits are served combinationally; a miss stalls the fetch until the line lands.
module instr_cache #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam int LO_W  = OFF_W + 2;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e             state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [NUM_LINES];
  logic [31:0]        data_q [NUM_LINES*WORDS_PER_LINE];
  logic [31:0]        base_q;
  logic [OFF_W-1:0]   k_q;
  logic [15:0]        miss_q;
  logic               flush_pend_q;

  logic [OFF_W-1:0] c_off;
  logic [IDX_W-1:0] c_idx;
  logic [TAG_W-1:0] c_tag;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             hit;
  logic             last;
  logic             unused_addr;

  assign c_off = cpu_addr[2 +: OFF_W];
  assign c_idx = cpu_addr[LO_W +: IDX_W];
  assign c_tag = cpu_addr[31 -: TAG_W];
  assign r_idx = base_q[LO_W +: IDX_W];
  assign r_tag = base_q[31 -: TAG_W];
  assign unused_addr = ^cpu_addr[1:0];

  assign hit  = cpu_req && valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign last = (k_q == OFF_W'(WORDS_PER_LINE - 1));

  assign cpu_instr  = data_q[{c_idx, c_off}];
  assign cpu_stall  = (state_q == REFILL) || (cpu_req && !hit);
  assign mem_req    = (state_q == REFILL);
  assign mem_addr   = base_q + {{(30-OFF_W){1'b0}}, k_q, 2'b00};
  assign miss_count = miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      k_q          <= '0;
      miss_q       <= '0;
      base_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush) valid_q <= '0;
          if (cpu_req && !hit) begin
            base_q  <= {cpu_addr[31:LO_W], {LO_W{1'b0}}};
            k_q     <= '0;
            miss_q  <= miss_q + 16'd1;
            state_q <= REFILL;
          end
        end
        REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_valid) begin
            k_q <= k_q + OFF_W'(1);
            if (last) begin
              state_q      <= IDLE;
              flush_pend_q <= 1'b0;
              // A flush seen during the refill also kills the new line
              if (flush || flush_pend_q) valid_q <= '0;
              else valid_q[r_idx] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == REFILL && mem_valid) begin
      data_q[{r_idx, k_q}] <= mem_rdata;
      if (last) tag_q[r_idx] <= r_tag;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a latency-programmable memory responder.
// Memory contents are a fixed function of the word address.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int req_cycles = 0;
  logic [31:0] addrq[$];

  always #5 clk = ~clk;

  instr_cache dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
    .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .miss_count(miss_count)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers lat cycles after each word request
  initial begin
    int cnt;
    logic [31:0] hold;
    cnt = 0;
    hold = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        cnt = 0;
        mem_valid = 1'b0;
      end else begin
        req_cycles++;
        if (cnt > 0) chk("addr_stable", mem_addr, hold);
        hold = mem_addr;
        if (cnt >= lat) begin
          mem_valid = 1'b1;
          mem_rdata = memword(mem_addr);
          addrq.push_back(mem_addr);
          cnt = 0;
        end else begin
          mem_valid = 1'b0;
          cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one address to completion; checks stall length and data
  task automatic fetch(input logic [31:0] a, input int exp_stalls,
                       input string tag);
    int n;
    n = 0;
    cpu_req = 1'b1;
    cpu_addr = a;
    #1;
    while (cpu_stall === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    chk({tag, "_instr"}, cpu_instr, memword(a));
    step();
    cpu_req = 1'b0;
  endtask

  task automatic chk_q(input string tag, input logic [31:0] b);
    chk({tag, "_nwords"}, 32'(addrq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < addrq.size())
        chk({tag, "_maddr"}, addrq[i], b + 32'(4 * i));
    end
    addrq.delete();
  endtask

  initial begin
    int n;
    int rc;
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_addr = '0;
    flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);

    // Cold miss, zero-wait memory
    addrq.delete();
    fetch(32'h0, 5, "cold0");
    chk_q("cold0", 32'h0);
    chk("cold0_miss", 32'(miss_count), 32'd1);

    // Hits in the same line never touch memory
    rc = req_cycles;
    fetch(32'h4, 0, "hit4");
    fetch(32'h8, 0, "hit8");
    fetch(32'hC, 0, "hitC");
    chk("hits_memreq", 32'(req_cycles - rc), 32'd0);
    chk("hits_miss", 32'(miss_count), 32'd1);

    // Conflict on index 0
    fetch(32'h100, 5, "conf100");
    chk_q("conf100", 32'h100);
    fetch(32'h0, 5, "conf0");
    chk_q("conf0", 32'h0);
    chk("conf_miss", 32'(miss_count), 32'd3);

    // Slow memory: 3 wait cycles per word
    lat = 3;
    fetch(32'h214, 17, "slow");
    chk_q("slow", 32'h210);
    chk("slow_miss", 32'(miss_count), 32'd4);
    lat = 0;

    // Flush in IDLE: same-cycle lookup still hits, next one misses
    cpu_req = 1'b1;
    cpu_addr = 32'h4;
    flush = 1'b1;
    #1;
    chk("iflush_stall", 32'(cpu_stall), 32'd0);
    chk("iflush_instr", cpu_instr, memword(32'h4));
    step();
    flush = 1'b0;
    cpu_req = 1'b0;
    fetch(32'h4, 5, "postflush");
    chk("postflush_miss", 32'(miss_count), 32'd5);

    // Flush pulsed during refill of 0x40
    lat = 3;
    cpu_req = 1'b1;
    cpu_addr = 32'h40;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("rflush_done", 32'(n < 100), 32'd1);
    chk("rflush_remiss", 32'(cpu_stall), 32'd1);
    addrq.delete();
    fetch(32'h40, 17, "rflush");
    chk("rflush_miss", 32'(miss_count), 32'd7);
    lat = 0;

    // Reset in the middle of a refill
    cpu_req = 1'b1;
    cpu_addr = 32'h80;
    step();
    step();
    step();
    chk("mid_k2_addr", mem_addr, 32'h88);
    rst = 1'b1;
    cpu_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_memreq", 32'(mem_req), 32'd0);
    chk("mid_rst_miss", 32'(miss_count), 32'd0);
    addrq.delete();
    fetch(32'h80, 5, "after_rst");
    chk_q("after_rst", 32'h80);
    chk("after_rst_miss", 32'(miss_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
